mac_frame_src: RTL and testbench

Stream source for the squared-sample MAC accumulator. Buffers 8-bit samples from an upstream ready/valid producer in a small FIFO and drives them onto the MAC's `a`/`valid_in` input, one sample per cycle, in frames of FRAME_LEN samples. After each frame it waits out the MAC pipeline, then pulses the MAC's synchronous reset to clear the accumulator and flags `frame_done`, so the consumer of `f`/`valid_out` sees one clean sum per frame.

---
 rtl/mac_frame_src_if.sv | 42 ++++
 rtl/mac_frame_src.sv | 145 ++++++++++++++
 tb/tb_mac_frame_src.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_frame_src_if.sv
// Interface bundling the upstream sample handshake and the MAC-side outputs
// of the frame source. "master" is the frame source's view, "slave" is the
// environment (producer plus MAC) view.
interface mac_frame_src_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          enable;
    logic [7:0]    a_out;
    logic          a_valid;
    logic          mac_rst;
    logic          frame_done;
    logic [CW-1:0] fifo_count;

    modport master (
        input  in_data,
        input  in_valid,
        input  enable,
        output in_ready,
        output a_out,
        output a_valid,
        output mac_rst,
        output frame_done,
        output fifo_count
    );

    modport slave (
        output in_data,
        output in_valid,
        output enable,
        input  in_ready,
        input  a_out,
        input  a_valid,
        input  mac_rst,
        input  frame_done,
        input  fifo_count
    );
endinterface

// File: rtl/mac_frame_src.sv
// Frame source for the squared-sample MAC: buffers upstream samples in a
// small FIFO, streams FRAME_LEN samples per frame to the MAC, waits out the
// MAC pipeline, then pulses the MAC reset together with frame_done.
module mac_frame_src #(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    mac_frame_src_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [4:0]    FRAME_LEN_C = 5'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    logic [4:0]    sent_r;
    logic          wait_cnt_r;
    logic [7:0]    a_out_r;
    logic          a_valid_r;
    logic          mac_rst_r;
    logic          frame_done_r;

    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;

    // Handshake decode: no bypass, so full blocks pushes even while popping.
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        if (count_r != DEPTH_C) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        push_s = bus.in_valid && in_ready_s;
        if ((state_r == ST_STREAM) && bus.enable && (count_r != {CW{1'b0}})) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame FSM: stream a frame, wait two cycles for the MAC pipeline to
    // drain, then hold the MAC in reset for one cycle while flagging done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_STREAM;
            sent_r       <= 5'd0;
            wait_cnt_r   <= 1'b0;
            a_out_r      <= 8'd0;
            a_valid_r    <= 1'b0;
            mac_rst_r    <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            a_valid_r <= 1'b0;
            case (state_r)
                ST_STREAM: begin
                    mac_rst_r    <= 1'b0;
                    frame_done_r <= 1'b0;
                    if (pop_s) begin
                        a_out_r   <= mem_r[rd_ptr_r];
                        a_valid_r <= 1'b1;
                        sent_r    <= sent_r + 5'd1;
                        if ((sent_r + 5'd1) == FRAME_LEN_C) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r) begin
                        mac_rst_r    <= 1'b1;
                        frame_done_r <= 1'b1;
                        wait_cnt_r   <= 1'b0;
                        state_r      <= ST_CLEAR;
                    end else begin
                        wait_cnt_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    mac_rst_r    <= 1'b0;
                    frame_done_r <= 1'b0;
                    sent_r       <= 5'd0;
                    state_r      <= ST_STREAM;
                end
                default: begin
                    state_r      <= ST_STREAM;
                    sent_r       <= 5'd0;
                    wait_cnt_r   <= 1'b0;
                    mac_rst_r    <= 1'b1;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.a_out      = a_out_r;
    assign bus.a_valid    = a_valid_r;
    assign bus.mac_rst    = mac_rst_r;
    assign bus.frame_done = frame_done_r;
    assign bus.fifo_count = count_r;
endmodule

// File: tb/tb_mac_frame_src.sv
// Scoreboard bench for mac_frame_src: two instances (FRAME_LEN 4 and 1),
// each feeding a behavioural squared-sample MAC. Stimulus pushes the
// hand-computed samples/sums into queues; a monitor pops and compares.
module tb_mac_frame_src;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_frame_src_if #(.DEPTH(8)) bus0 ();
    mac_frame_src_if #(.DEPTH(8)) bus1 ();

    mac_frame_src #(.DEPTH(8), .FRAME_LEN(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mac_frame_src #(.DEPTH(8), .FRAME_LEN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    int last_av [2];
    int prev_av [2];
    logic [31:0] exp_a [$];
    logic [31:0] exp_f [$];

    // DUT outputs gathered into arrays so MAC model and monitor loop per instance
    logic [7:0]  m_a   [2];
    logic        m_v   [2];
    logic        m_rst [2];
    logic        m_fd  [2];
    logic [7:0]  m_ar  [2];
    logic        m_vr  [2];
    logic [19:0] m_f   [2];
    logic        m_vo  [2];

    always_comb begin
        m_a[0] = bus0.a_out;   m_v[0] = bus0.a_valid;
        m_rst[0] = bus0.mac_rst; m_fd[0] = bus0.frame_done;
        m_a[1] = bus1.a_out;   m_v[1] = bus1.a_valid;
        m_rst[1] = bus1.mac_rst; m_fd[1] = bus1.frame_done;
    end

    // Behavioural MAC: register sample, then accumulate its square.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_rst[i]) begin
                m_ar[i] <= 8'd0; m_vr[i] <= 1'b0; m_f[i] <= 20'd0; m_vo[i] <= 1'b0;
            end else begin
                m_ar[i] <= m_a[i];
                m_vr[i] <= m_v[i];
                m_vo[i] <= m_vr[i];
                if (m_vr[i]) m_f[i] <= m_f[i] + 20'(m_ar[i]) * 20'(m_ar[i]);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: compare every presented sample, sum and frame pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_v[i] === 1'b1) begin
                if (exp_a.size() == 0) chk("a_unexpected", {24'd0, m_a[i]}, 32'hFFFF_FFFF);
                else chk("a_out", {24'd0, m_a[i]}, exp_a.pop_front());
                prev_av[i] = last_av[i];
                last_av[i] = cyc;
            end
            if (m_vo[i] === 1'b1) begin
                if (exp_f.size() == 0) chk("f_unexpected", {12'd0, m_f[i]}, 32'hFFFF_FFFF);
                else chk("mac_f", {12'd0, m_f[i]}, exp_f.pop_front());
            end
            if (m_fd[i] === 1'b1) begin
                fd_cnt++;
                chk("fd_with_mac_rst", {31'd0, m_rst[i]}, 32'd1);
                chk("fd_delay", cyc - last_av[i], 32'd2);
            end
        end
    end

    // Push one sample on the selected instance; call at a negedge.
    task automatic push(input int sel, input logic [7:0] d);
        int n = 0;
        if (sel == 0) begin bus0.in_data = d; bus0.in_valid = 1'b1; end
        else begin bus1.in_data = d; bus1.in_valid = 1'b1; end
        while (((sel == 0) ? bus0.in_ready : bus1.in_ready) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", n, 32'd0);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_f.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", n, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus0.in_data = 8'd0; bus0.in_valid = 1'b0; bus0.enable = 1'b0;
        bus1.in_data = 8'd0; bus1.in_valid = 1'b0; bus1.enable = 1'b0;
        last_av = '{0, 0};
        prev_av = '{0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_valid", {31'd0, bus0.a_valid}, 32'd0);
        chk("rst_a_out", {24'd0, bus0.a_out}, 32'd0);
        chk("rst_mac_rst", {31'd0, bus0.mac_rst}, 32'd1);
        chk("rst_frame_done", {31'd0, bus0.frame_done}, 32'd0);
        chk("rst_fifo_count", {28'd0, bus0.fifo_count}, 32'd0);
        chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mac_rst_release", {31'd0, bus0.mac_rst}, 32'd0);

        // Basic frame of four samples
        fd_cnt = 0;
        bus0.enable = 1'b1;
        exp_a.push_back(21); exp_a.push_back(36); exp_a.push_back(64); exp_a.push_back(255);
        exp_f.push_back(441); exp_f.push_back(1737); exp_f.push_back(5833); exp_f.push_back(70858);
        push(0, 8'd21); push(0, 8'd36); push(0, 8'd64); push(0, 8'd255);
        drain();
        chk("t1_frame_done_count", fd_cnt, 32'd1);
        chk("t1_f_cleared", {12'd0, m_f[0]}, 32'd0);
        chk("t1_back_to_back", last_av[0] - prev_av[0], 32'd1);

        // FIFO fill to full with enable low, then release
        fd_cnt = 0;
        bus0.enable = 1'b0;
        for (int k = 1; k <= 9; k++) exp_a.push_back(k);
        exp_f.push_back(1);  exp_f.push_back(5);  exp_f.push_back(14);  exp_f.push_back(30);
        exp_f.push_back(25); exp_f.push_back(61); exp_f.push_back(110); exp_f.push_back(174);
        exp_f.push_back(81);
        for (int k = 1; k <= 8; k++) push(0, 8'(k));
        chk("full_in_ready", {31'd0, bus0.in_ready}, 32'd0);
        chk("full_count", {28'd0, bus0.fifo_count}, 32'd8);
        bus0.in_data = 8'd9; bus0.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_count", {28'd0, bus0.fifo_count}, 32'd8);
        chk("stall_no_pop", {31'd0, bus0.a_valid}, 32'd0);
        bus0.enable = 1'b1;
        @(negedge clk);
        chk("ready_after_pop", {31'd0, bus0.in_ready}, 32'd1);
        chk("count_after_pop", {28'd0, bus0.fifo_count}, 32'd7);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("count_push_pop", {28'd0, bus0.fifo_count}, 32'd7);
        drain();
        chk("t3_frame_done_count", fd_cnt, 32'd2);
        do_reset();

        // Toggling enable produces gaps
        fd_cnt = 0;
        for (int k = 1; k <= 4; k++) exp_a.push_back(k);
        exp_f.push_back(1); exp_f.push_back(5); exp_f.push_back(14); exp_f.push_back(30);
        for (int c = 0; c < 14; c++) begin
            bus0.in_valid = (c < 4) ? 1'b1 : 1'b0;
            bus0.in_data  = 8'(c + 1);
            bus0.enable   = (c % 2 == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        bus0.enable   = 1'b1;
        drain();
        chk("t4_frame_done_count", fd_cnt, 32'd1);
        chk("t4_gap", last_av[0] - prev_av[0], 32'd2);

        // Reset mid-frame flushes FIFO and abandons frame
        fd_cnt = 0;
        bus0.enable = 1'b0;
        exp_a.push_back(7); exp_a.push_back(8);
        exp_f.push_back(49); exp_f.push_back(113);
        push(0, 8'd7); push(0, 8'd8); push(0, 8'd9); push(0, 8'd10);
        bus0.enable = 1'b1;
        repeat (2) @(negedge clk);
        bus0.enable = 1'b0;
        drain();
        chk("t5_count_before_rst", {28'd0, bus0.fifo_count}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_flushed", {28'd0, bus0.fifo_count}, 32'd0);
        chk("t5_mac_rst", {31'd0, bus0.mac_rst}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_mac_cleared", {12'd0, m_f[0]}, 32'd0);
        chk("t5_no_frame_done", fd_cnt, 32'd0);
        bus0.enable = 1'b1;
        for (int k = 0; k < 4; k++) exp_a.push_back(5);
        exp_f.push_back(25); exp_f.push_back(50); exp_f.push_back(75); exp_f.push_back(100);
        for (int k = 0; k < 4; k++) push(0, 8'd5);
        drain();
        chk("t5_frame_done_count", fd_cnt, 32'd1);

        // FRAME_LEN=1 instance: two single-sample frames
        fd_cnt = 0;
        bus1.enable = 1'b1;
        exp_a.push_back(10); exp_a.push_back(10);
        exp_f.push_back(100); exp_f.push_back(100);
        push(1, 8'd10); push(1, 8'd10);
        drain();
        chk("t6_frame_done_count", fd_cnt, 32'd2);
        chk("t6_pop_spacing", last_av[1] - prev_av[1], 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
